// File: rtl/bits_please_pkg.sv
// Shared types and constants for the score display datapath.
// Latency: none (declarations only).
// Backpressure: not applicable.
package bits_please_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } score_bcd_state_t;

   // Largest score that fits in four BCD digits; larger scores saturate to it.
   localparam int SCORE_MAX   = 9999;
   localparam int BCD_DIGIT_W = 4;

   // Field offsets inside the 32-bit {user_id, score} display word.
   localparam int USERID_LSB  = 16;
   localparam int SCORE_LSB   = 0;

endpackage

// File: rtl/bcd_add3.sv
// One shift-add-3 correction cell: adds 3 to a BCD digit that is 5 or more.
// Latency: purely combinational.
// Backpressure: not applicable.
//
// Ports:
//   d_i : digit before correction
//   q_o : digit after correction, ready to be shifted left
module bcd_add3
   import bits_please_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] d_i,
   output logic [BCD_DIGIT_W-1:0] q_o
);

   always_comb begin
      q_o = d_i;
      if (d_i >= BCD_DIGIT_W'(5)) begin
         q_o = d_i + BCD_DIGIT_W'(3);
      end
   end

endmodule

// File: rtl/score_bcd_packer.sv
// Converts a binary score to four BCD digits (one bit per clock) and packs {user_id, bcd} for display.
// Latency: load sampled at edge E0, done pulses in the cycle after edge E0+BIN_W.
// Backpressure: none; load while busy is dropped, so the producer must wait for done or !busy.
//
// Build option: define SCORE_BCD_AUTO_EN to start a conversion whenever bin_in changes
// from the last accepted value, in addition to the external load.
//
// Ports:
//   clk        : core clock
//   rst        : asynchronous active-low reset
//   bin_in     : binary score, sampled on an accepted start
//   user_id    : BCD-encoded user ID, sampled with bin_in
//   load       : start request, level-sampled every edge
//   busy       : conversion in progress
//   done       : one-cycle pulse when packed_out updates
//   overflow   : last accepted score exceeded 9999 (held until next result)
//   packed_out : {user_id, bcd3, bcd2, bcd1, bcd0}, held between conversions
module score_bcd_packer
   import bits_please_pkg::*;
#(
   parameter int BIN_W  = 14,
   parameter int DIGITS = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [BIN_W-1:0] bin_in,
   input  logic [15:0]      user_id,
   input  logic             load,
   output logic             busy,
   output logic             done,
   output logic             overflow,
   output logic [31:0]      packed_out
);

   localparam int SCR_W = DIGITS * BCD_DIGIT_W;
   localparam int CNT_W = $clog2(BIN_W + 1);

   localparam logic [BIN_W-1:0] SAT_VAL   = BIN_W'(SCORE_MAX);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

   score_bcd_state_t  state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [SCR_W-1:0]  scratch_q, scratch_d;
   logic [SCR_W-1:0]  scr_adj;
   logic [BIN_W-1:0]  operand_q, operand_d;
   logic [15:0]       uid_q, uid_d;
   logic              ovf_q, ovf_d;
   logic [31:0]       packed_q, packed_d;
   logic              overflow_q, overflow_d;
   logic              done_q, done_d;
   logic              start;

   // Add-3 correction applied to every scratch digit before each shift.
   for (genvar g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
         .d_i (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .q_o (scr_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
   end

`ifdef SCORE_BCD_AUTO_EN
   // Last accepted score; a difference in IDLE acts like a load.
   logic [BIN_W-1:0] last_q, last_d;
   assign start = load | (bin_in != last_q);
`else
   assign start = load;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      scratch_d  = scratch_q;
      operand_d  = operand_q;
      uid_d      = uid_q;
      ovf_d      = ovf_q;
      packed_d   = packed_q;
      overflow_d = overflow_q;
      done_d     = 1'b0;
`ifdef SCORE_BCD_AUTO_EN
      last_d     = last_q;
`endif

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = SHIFT;
               uid_d     = user_id;
               ovf_d     = (bin_in > SAT_VAL);
               // Saturating up front keeps digit 3 from ever carrying out.
               operand_d = (bin_in > SAT_VAL) ? SAT_VAL : bin_in;
               scratch_d = '0;
               cnt_d     = '0;
`ifdef SCORE_BCD_AUTO_EN
               last_d    = bin_in;
`endif
            end
         end

         SHIFT: begin
            // {scratch, operand} shifted left as one wide register.
            scratch_d = {scr_adj[SCR_W-2:0], operand_q[BIN_W-1]};
            operand_d = {operand_q[BIN_W-2:0], 1'b0};
            cnt_d     = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_STEP) begin
               state_d                         = IDLE;
               packed_d[USERID_LSB +: 16]      = uid_q;
               packed_d[SCORE_LSB +: SCR_W]    = scratch_d;
               overflow_d                      = ovf_q;
               done_d                          = 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         scratch_q  <= '0;
         operand_q  <= '0;
         uid_q      <= '0;
         ovf_q      <= 1'b0;
         packed_q   <= '0;
         overflow_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         scratch_q  <= scratch_d;
         operand_q  <= operand_d;
         uid_q      <= uid_d;
         ovf_q      <= ovf_d;
         packed_q   <= packed_d;
         overflow_q <= overflow_d;
         done_q     <= done_d;
      end
   end

`ifdef SCORE_BCD_AUTO_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_q <= '0;
      end else begin
         last_q <= last_d;
      end
   end
`endif

   assign busy       = (state_q == SHIFT);
   assign done       = done_q;
   assign overflow   = overflow_q;
   assign packed_out = packed_q;

endmodule

// File: tb/tb_score_bcd_packer.sv
module tb_score_bcd_packer;

   logic        clk;
   logic        rst;
   logic [13:0] bin_in;
   logic [15:0] user_id;
   logic        load;
   logic        busy;
   logic        done;
   logic        overflow;
   logic [31:0] packed_out;

   int nchecks = 0;
   int nerr    = 0;

   score_bcd_packer #(.BIN_W(14), .DIGITS(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .bin_in     (bin_in),
      .user_id    (user_id),
      .load       (load),
      .busy       (busy),
      .done       (done),
      .overflow   (overflow),
      .packed_out (packed_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge and settle; inputs are driven and outputs sampled here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchecks++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: decimal digits of the saturated score, computed arithmetically.
   function automatic logic [31:0] model_word(input int b, input int u);
      int s;
      logic [3:0] d3, d2, d1, d0;
      logic [15:0] uu;
      s  = (b > 9999) ? 9999 : b;
      d3 = 4'(s / 1000);
      d2 = 4'((s / 100) % 10);
      d1 = 4'((s / 10) % 10);
      d0 = 4'(s % 10);
      uu = 16'(u);
      return {uu, d3, d2, d1, d0};
   endfunction

   // One load pulse, then wait (bounded) for done; reports busy cycles and latency.
   task automatic convert(input int b, input int u, output int busy_cyc, output int lat);
      bin_in  = 14'(b);
      user_id = 16'(u);
      load    = 1'b1;
      tick();
      load     = 1'b0;
      busy_cyc = 0;
      lat      = 0;
      while (!done && lat < 40) begin
         if (busy) busy_cyc++;
         tick();
         lat++;
      end
   endtask

   initial begin
      int bc, lat, cnt, first_t, prev_t, gap_bad, vals_bad;
      int rb, ru;
      logic [31:0] seen;

      rst = 1'b0; load = 1'b0; bin_in = '0; user_id = '0;
      #2;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      check("rst_packed", packed_out, 32'h0);
      tick();
      tick();
      rst = 1'b1;
      tick();

`ifndef SCORE_BCD_AUTO_EN
      // Basic conversion
      convert(1234, 16'h0042, bc, lat);
      check("basic_latency", 32'(lat), 32'd14);
      check("basic_busy_cycles", 32'(bc), 32'd14);
      check("basic_packed", packed_out, 32'h0042_1234);
      check("basic_ovf", 32'(overflow), 32'd0);
      tick();
      check("basic_done_one_cycle", 32'(done), 32'd0);
      check("basic_packed_held", packed_out, 32'h0042_1234);

      // Saturation
      convert(12000, 16'h0001, bc, lat);
      check("sat12000_packed", packed_out, 32'h0001_9999);
      check("sat12000_ovf", 32'(overflow), 32'd1);
      convert(16383, 16'h0002, bc, lat);
      check("sat16383_packed", packed_out, 32'h0002_9999);
      check("sat16383_ovf", 32'(overflow), 32'd1);
      convert(0, 16'h0003, bc, lat);
      check("zero_packed", packed_out, 32'h0003_0000);
      check("zero_ovf", 32'(overflow), 32'd0);
      convert(10000, 16'h0004, bc, lat);
      check("sat10000_ovf", 32'(overflow), 32'd1);
      convert(9999, 16'h0004, bc, lat);
      check("edge9999_ovf", 32'(overflow), 32'd0);
      check("edge9999_packed", packed_out, 32'h0004_9999);

      // Randomized against the arithmetic model
      for (int i = 0; i < 10; i++) begin
         rb = int'($urandom_range(0, 16383));
         ru = int'($urandom_range(0, 65535));
         convert(rb, ru, bc, lat);
         check("rand_latency", 32'(lat), 32'd14);
         check("rand_packed", packed_out, model_word(rb, ru));
         check("rand_ovf", 32'(overflow), (rb > 9999) ? 32'd1 : 32'd0);
      end

      // Loads while busy are ignored
      tick();
      bin_in = 14'd321; user_id = 16'h0077; load = 1'b1;
      tick();
      cnt = 0; seen = '0;
      for (int i = 1; i <= 40; i++) begin
         if (i == 3 || i == 10) begin
            load = 1'b1; bin_in = 14'd555;
         end else begin
            load = 1'b0;
         end
         tick();
         if (done) begin
            cnt++;
            seen = packed_out;
         end
      end
      load = 1'b0;
      check("ignore_done_count", 32'(cnt), 32'd1);
      check("ignore_value", seen, 32'h0077_0321);

      // Load held high restarts every 15 cycles
      bin_in = 14'd7; user_id = 16'h0008; load = 1'b1;
      cnt = 0; first_t = 0; prev_t = 0; gap_bad = 0; vals_bad = 0;
      for (int t = 1; t <= 60; t++) begin
         tick();
         if (done) begin
            cnt++;
            if (cnt == 1) first_t = t;
            else if (t - prev_t != 15) gap_bad++;
            if (packed_out[15:0] !== 16'h0007) vals_bad++;
            prev_t = t;
         end
      end
      load = 1'b0;
      check("held_first_done", 32'(first_t), 32'd15);
      check("held_done_count", 32'(cnt), 32'd4);
      check("held_bad_gaps", 32'(gap_bad), 32'd0);
      check("held_bad_values", 32'(vals_bad), 32'd0);
      tick();
      tick();
      check("held_release_idle", 32'(busy), 32'd0);

      // Reset mid-conversion
      bin_in = 14'd4321; user_id = 16'h0011; load = 1'b1;
      tick();
      load = 1'b0;
      repeat (7) tick();
      check("pre_rst_busy", 32'(busy), 32'd1);
      rst = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_ovf", 32'(overflow), 32'd0);
      check("midrst_packed", packed_out, 32'h0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      check("post_rst_idle", 32'(busy), 32'd0);
      convert(9999, 16'h0012, bc, lat);
      check("post_rst_latency", 32'(lat), 32'd14);
      check("post_rst_packed", packed_out[15:0], 32'h9999);
`else
      // Automatic start on score change
      repeat (5) tick();
      check("auto_quiet_busy", 32'(busy), 32'd0);
      bin_in = 14'd500; user_id = 16'h0005;
      lat = 0;
      tick();
      while (!done && lat < 40) begin
         tick();
         lat++;
      end
      check("auto_done_seen", 32'(done), 32'd1);
      check("auto_packed", packed_out[15:0], 32'h0500);
      check("auto_ovf", 32'(overflow), 32'd0);
      cnt = 0;
      for (int t = 0; t < 40; t++) begin
         tick();
         if (done) cnt++;
      end
      check("auto_no_repeat", 32'(cnt), 32'd0);
      convert(1234, 16'h0042, bc, lat);
      check("auto_ext_load", packed_out, 32'h0042_1234);
      check("auto_ext_latency", 32'(lat), 32'd14);
`endif

      $display("Result: errors=%0d of %0d checks", nerr, nchecks);
      $finish;
   end

endmodule

// File: doc/score_bcd_packer.md
# score_bcd_packer

Sequential binary-to-BCD converter between the game score datapath and the score display mux. It converts the 14-bit binary score to four BCD digits using shift-add-3, one bit per clock. It then packs the digits with the 16-bit user ID into the 32-bit `{user_id, score}` word consumed by the seven-segment display path. Scores above 9999 saturate, and an overflow flag is raised.

## Interface
- `BIN_W`, default 14: binary score width. Must be 14 or more.
- `DIGITS`, default 4: number of BCD digits produced. Fixed at 4 so the output packs into 32 bits.
- `clk` input 1: system clock. Single clock domain.
- `rst` input 1: reset, asynchronous, active-low.
- `bin_in` input BIN_W: binary score. Sampled only on an accepted start.
- `user_id` input 16: user ID, BCD-encoded upstream. Sampled together with `bin_in`.
- `load` input 1: start-conversion request. Level-sampled on every clock edge.
- `busy` output 1: high while a conversion is in progress.
- `done` output 1: one-cycle pulse when `packed_out` updates.
- `overflow` output 1: high when the last accepted `bin_in` was greater than 9999. Held until the next result.
- `packed_out` output 32: `{user_id[15:0], bcd3, bcd2, bcd1, bcd0}`, with `bcd3` as the most significant digit. Held between conversions.

## Operation
- FSM states:
  - `IDLE` → `SHIFT` on an edge where `load=1`.
  - `SHIFT` → `IDLE` on the edge that completes step BIN_W.
- Accept (edge in `IDLE` with `load=1`):
  - Capture `user_id` into a holding register.
  - Capture the operand as `min(bin_in, 9999)`, and capture `ovf = (bin_in > 9999)`.
  - Clear the BCD scratch register and the step counter. Set `busy` to 1.
- `SHIFT` step, once per edge:
  - For each 4-bit scratch digit, add 3 if the digit is ≥ 5.
  - Then shift the `{scratch, operand}` pair left by 1.
  - Increment the step counter.
- Completion (edge performing step BIN_W):
  - Load `packed_out` from `{held user_id, final scratch}` and `overflow` from `ovf`.
  - Set `done` to 1 for one cycle, clear `busy`, return to `IDLE`.
- `load` while `busy=1` is ignored. No queuing, no error flag.
- `load` held high continuously restarts a conversion every BIN_W+1 cycles.
- `load=1` in the cycle where `done=1` is accepted, because the FSM is already in `IDLE`.
- Width rules:
  - The scratch register is 16 bits wide; no carry out of digit 3 can occur after saturation.
  - The step counter is `$clog2(BIN_W+1)` bits.
- Reset, asserted at any time including mid-conversion:
  - Conversion aborts and the FSM goes to `IDLE`.
  - `busy=0`, `done=0`, `overflow=0`, `packed_out=32'h0`.
  - Scratch, operand, and counter are all cleared.

## Timing
- Latency: `load` sampled at edge E0, `done` high in the cycle following edge E0+BIN_W (edge 14 by default).
- `packed_out` and `overflow` change only on the same edge that raises `done`.
- `busy` is high in the cycles following edges E0 through E0+BIN_W−1, which is BIN_W cycles.
- Minimum spacing between accepted loads: BIN_W+1 cycles without the auto feature, and likewise with it.
- Reset release is synchronous to the design; the first `load` is sampled on the first edge after `rst` goes high.

## Configuration
- `SCORE_BCD_AUTO_EN` defined:
  - The block keeps a register holding the last accepted `bin_in`.
  - In `IDLE`, it starts a conversion internally when `bin_in` differs from that register, exactly as if `load=1` had been asserted.
  - The external `load` still works.
  - The register resets to 0, so a nonzero score after reset triggers a conversion automatically.
- `SCORE_BCD_AUTO_EN` undefined:
  - Conversions start only on `load`.
  - No comparison register is built.

## Structure
- Shared package `bits_please_pkg`:
  - `score_bcd_state_t` enum (`IDLE`, `SHIFT`).
  - Constant `SCORE_MAX = 9999`.
  - Constant `BCD_DIGIT_W = 4`.
  - Packed-word field offsets: `USERID_LSB = 16`, `SCORE_LSB = 0`.
- Sub-module `bcd_add3`: purely combinational 4-bit "add 3 if ≥ 5" cell, instantiated DIGITS times.
- Everything else stays in `score_bcd_packer`.

## Test plan
- Reset, then `bin_in=1234`, `user_id=16'h0042`, one-cycle `load`:
  - `busy` high for 14 cycles, then `done` pulses once.
  - `packed_out=32'h0042_1234`, `overflow=0`.
- `bin_in=12000` and `bin_in=16383` with a load each:
  - `packed_out[15:0]=16'h9999`, `overflow=1`.
  - A following load with 0 gives `16'h0000` and `overflow=0`.
- Load accepted, then `load` pulsed again on cycles 3 and 10 with a different `bin_in`:
  - Only the first value appears.
  - Exactly one `done` pulse.
- `load` held high with `bin_in=7`:
  - `done` every 15 cycles.
  - Output constant at `16'h0007`.
- `rst` asserted at cycle 7 of a conversion:
  - All outputs are 0 immediately, asynchronously.
  - After release, a new load of 9999 yields `16'h9999`.
- With `SCORE_BCD_AUTO_EN` defined:
  - Step `bin_in` 0→500 and never assert `load`: `done` pulses and `packed_out[15:0]=16'h0500`.
  - Holding `bin_in` at 500 afterwards produces no further `done`.
